// File: rtl/issue_instr_queue_pkg.sv
// issue_instr_queue_pkg: decoded-entry and queue-entry types shared by the issue queue
package issue_instr_queue_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  fu;
    logic [4:0]  rd;
  } scoreboard_entry_t;
  typedef struct packed {
    scoreboard_entry_t sbe;
    logic [31:0]       orig_instr;
    logic              is_ctrl_flow;
    logic              is_zcmt;
  } issue_q_entry_t;
endpackage

// File: rtl/issue_instr_queue_if.sv
// issue_instr_queue_if: valid/ack channel carrying one queue entry with its sidecar bits
interface issue_instr_queue_if import issue_instr_queue_pkg::*; ();
  issue_q_entry_t instr;
  logic           valid;
  logic           ack;
  modport master (output instr, valid, input ack);
  modport slave (input instr, valid, output ack);
endinterface

// File: rtl/issue_instr_queue_ctrl.sv
// issue_queue_ctrl: pointers, occupancy, control-flow count and handshakes (ISSUE_QUEUE_BYPASS_EN adds empty-queue bypass)
module issue_queue_ctrl import issue_instr_queue_pkg::*; #(
  parameter int DEPTH         = 4,
  parameter int MAX_CTRL_FLOW = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       valid_i,
  input  logic                       is_ctrl_flow_i,
  input  logic                       head_ctrl_flow_i,
  input  logic                       issue_ack_i,
  output logic                       ack_o,
  output logic                       stall_o,
  output logic                       we_o,
  output logic                       bypass_o,
  output logic                       head_valid_o,
  output logic [$clog2(DEPTH)-1:0]   waddr_o,
  output logic [$clog2(DEPTH)-1:0]   raddr_o,
  output logic [$clog2(DEPTH):0]     usage_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(MAX_CTRL_FLOW + 1);
  logic [AW:0]   wptr_q, rptr_q, usage_q;
  logic [CW-1:0] cnt_q;
  logic          full, empty, limit, deq, take;
  assign full    = usage_q == (AW+1)'(DEPTH);
  assign empty   = usage_q == '0;
  assign limit   = cnt_q == CW'(MAX_CTRL_FLOW);
  assign ack_o   = valid_i & !rst_i & !full & !flush_i & !(is_ctrl_flow_i & limit);
  assign stall_o = valid_i & is_ctrl_flow_i & limit & !full;
  assign deq     = !empty & issue_ack_i;
`ifdef ISSUE_QUEUE_BYPASS_EN
  assign bypass_o = empty & valid_i & !flush_i & !rst_i;
  assign take     = bypass_o & issue_ack_i;
`else
  assign bypass_o = 1'b0;
  assign take     = 1'b0;
`endif
  // a bypassed entry consumed in the same cycle never touches storage
  assign we_o         = ack_o & !take;
  assign head_valid_o = !empty | bypass_o;
  assign waddr_o      = wptr_q[AW-1:0];
  assign raddr_o      = rptr_q[AW-1:0];
  assign usage_o      = usage_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i || flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      usage_q <= '0;
      cnt_q   <= '0;
    end else begin
      wptr_q  <= wptr_q + (AW+1)'(we_o);
      rptr_q  <= rptr_q + (AW+1)'(deq);
      usage_q <= usage_q + (AW+1)'(we_o) - (AW+1)'(deq);
      cnt_q   <= cnt_q + CW'(we_o & is_ctrl_flow_i) - CW'(deq & head_ctrl_flow_i);
    end
  end
  a_usage: assert property (@(posedge clk_i) disable iff (rst_i) usage_q <= (AW+1)'(DEPTH));
  a_cnt:   assert property (@(posedge clk_i) disable iff (rst_i) cnt_q <= CW'(MAX_CTRL_FLOW));
  a_full:  assert property (@(posedge clk_i) disable iff (rst_i) !(we_o && full));
endmodule

// File: rtl/issue_instr_queue.sv
// issue_instr_queue: in-order decode-to-issue entry queue (ISSUE_QUEUE_BYPASS_EN enables zero-latency empty bypass)
module issue_instr_queue import issue_instr_queue_pkg::*; #(
  parameter int DEPTH         = 4,
  parameter int MAX_CTRL_FLOW = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  issue_instr_queue_if.slave        dec,
  issue_instr_queue_if.master       iss,
  output logic [$clog2(DEPTH):0]    usage_o,
  output logic                      ctrl_flow_stall_o
);
  issue_q_entry_t               mem [DEPTH];
  issue_q_entry_t               head;
  logic                         we, bypass;
  logic [$clog2(DEPTH)-1:0]     waddr, raddr;
  assign head      = mem[raddr];
  assign iss.instr = bypass ? dec.instr : head;
  always_ff @(posedge clk_i) if (we) mem[waddr] <= dec.instr;
  issue_queue_ctrl #(.DEPTH(DEPTH), .MAX_CTRL_FLOW(MAX_CTRL_FLOW)) u_ctrl (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .flush_i          (flush_i),
    .valid_i          (dec.valid),
    .is_ctrl_flow_i   (dec.instr.is_ctrl_flow),
    .head_ctrl_flow_i (head.is_ctrl_flow),
    .issue_ack_i      (iss.ack),
    .ack_o            (dec.ack),
    .stall_o          (ctrl_flow_stall_o),
    .we_o             (we),
    .bypass_o         (bypass),
    .head_valid_o     (iss.valid),
    .waddr_o          (waddr),
    .raddr_o          (raddr),
    .usage_o          (usage_o)
  );
endmodule

// File: tb/tb_issue_instr_queue.sv
// tb_issue_instr_queue: table-driven check of the issue queue plus reset and bypass sequences
module tb_issue_instr_queue;
  import issue_instr_queue_pkg::*;
`ifdef ISSUE_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, flush, stall;
  logic [2:0] usage;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  issue_instr_queue_if dec_if ();
  issue_instr_queue_if iss_if ();
  issue_instr_queue #(.DEPTH(4), .MAX_CTRL_FLOW(1)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .dec(dec_if), .iss(iss_if),
    .usage_o(usage), .ctrl_flow_stall_o(stall)
  );
  typedef struct {
    logic v, cf; logic [31:0] pc; logic fl, ia;
    logic e_ack, e_vld; logic [31:0] e_pc; int e_use; logic e_stall;
  } vec_t;
  vec_t tv[$];
  function automatic vec_t mk(logic v, cf, logic [31:0] pc, logic fl, ia, e_ack, e_vld,
                              logic [31:0] e_pc, int e_use, logic e_stall);
    vec_t r;
    r.v = v; r.cf = cf; r.pc = pc; r.fl = fl; r.ia = ia;
    r.e_ack = e_ack; r.e_vld = e_vld; r.e_pc = e_pc; r.e_use = e_use; r.e_stall = e_stall;
    return r;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input logic v, cf, input logic [31:0] pc, input logic fl, ia);
    dec_if.instr = '0;
    dec_if.instr.sbe.pc = pc;
    dec_if.instr.sbe.fu = 4'h1;
    dec_if.instr.orig_instr = pc ^ 32'h13;
    dec_if.instr.is_ctrl_flow = cf;
    dec_if.valid = v;
    flush = fl;
    iss_if.ack = ia;
  endtask
  initial begin
    tv.push_back(mk(1,0,32'h8000_0000,0,0, 1,BYP,32'h8000_0000,0,0));
    tv.push_back(mk(1,0,32'h8000_0004,0,0, 1,1,32'h8000_0000,1,0));
    tv.push_back(mk(1,0,32'h8000_0008,0,0, 1,1,32'h8000_0000,2,0));
    tv.push_back(mk(1,0,32'h8000_000C,0,0, 1,1,32'h8000_0000,3,0));
    tv.push_back(mk(1,0,32'h8000_0010,0,0, 0,1,32'h8000_0000,4,0));
    tv.push_back(mk(1,0,32'h8000_0010,0,1, 0,1,32'h8000_0000,4,0));
    tv.push_back(mk(0,0,32'h0,0,1, 0,1,32'h8000_0004,3,0));
    tv.push_back(mk(0,0,32'h0,0,1, 0,1,32'h8000_0008,2,0));
    tv.push_back(mk(0,0,32'h0,0,1, 0,1,32'h8000_000C,1,0));
    tv.push_back(mk(0,0,32'h0,0,0, 0,0,32'h0,0,0));
    tv.push_back(mk(0,0,32'h0,0,1, 0,0,32'h0,0,0));
    tv.push_back(mk(0,0,32'h0,0,0, 0,0,32'h0,0,0));
    tv.push_back(mk(1,1,32'h9000_0000,0,0, 1,BYP,32'h9000_0000,0,0));
    tv.push_back(mk(1,1,32'h9000_0004,0,0, 0,1,32'h9000_0000,1,1));
    tv.push_back(mk(1,1,32'h9000_0004,0,1, 0,1,32'h9000_0000,1,1));
    tv.push_back(mk(1,1,32'h9000_0004,0,0, 1,BYP,32'h9000_0004,0,0));
    tv.push_back(mk(0,0,32'h0,0,0, 0,1,32'h9000_0004,1,0));
    tv.push_back(mk(1,0,32'hA000_0000,0,0, 1,1,32'h9000_0004,1,0));
    tv.push_back(mk(1,0,32'hA000_0004,0,0, 1,1,32'h9000_0004,2,0));
    tv.push_back(mk(1,0,32'hA000_0008,1,0, 0,1,32'h9000_0004,3,0));
    tv.push_back(mk(0,0,32'h0,0,0, 0,0,32'h0,0,0));
    tv.push_back(mk(1,1,32'hB000_0000,0,0, 1,BYP,32'hB000_0000,0,0));
    tv.push_back(mk(1,0,32'hB000_0004,0,0, 1,1,32'hB000_0000,1,0));
    tv.push_back(mk(0,0,32'h0,0,0, 0,1,32'hB000_0000,2,0));
    rst = 1'b1;
    drive(1, 0, 32'h7000_0000, 0, 0);
    #2;
    chk("reset_ack", 32'(dec_if.ack), 32'h0);
    chk("reset_valid", 32'(iss_if.valid), 32'h0);
    chk("reset_usage", 32'(usage), 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].v, tv[i].cf, tv[i].pc, tv[i].fl, tv[i].ia);
      #4;
      chk($sformatf("v%0d_ack", i), 32'(dec_if.ack), 32'(tv[i].e_ack));
      chk($sformatf("v%0d_valid", i), 32'(iss_if.valid), 32'(tv[i].e_vld));
      chk($sformatf("v%0d_usage", i), 32'(usage), 32'(tv[i].e_use));
      chk($sformatf("v%0d_stall", i), 32'(stall), 32'(tv[i].e_stall));
      if (tv[i].e_vld) chk($sformatf("v%0d_pc", i), iss_if.instr.sbe.pc, tv[i].e_pc);
      @(posedge clk); #1;
    end
    drive(0, 0, 32'h0, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(iss_if.valid), 32'h0);
    chk("async_rst_usage", 32'(usage), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1, 0, 32'hC000_0000, 0, 0);
    #4;
    chk("post_rst_ack", 32'(dec_if.ack), 32'h1);
    chk("post_rst_valid0", 32'(iss_if.valid), 32'(BYP));
    @(posedge clk); #1;
    drive(0, 0, 32'h0, 0, 0);
    #1;
    chk("post_rst_valid1", 32'(iss_if.valid), 32'h1);
    chk("post_rst_pc", iss_if.instr.sbe.pc, 32'hC000_0000);
    chk("post_rst_usage", 32'(usage), 32'h1);
    drive(0, 0, 32'h0, 1, 0);
    @(posedge clk); #1;
    drive(1, 0, 32'hD000_0000, 0, 1);
    dec_if.instr.orig_instr = 32'h0000_0013;
    #4;
    chk("byp_ack", 32'(dec_if.ack), 32'h1);
    chk("byp_valid0", 32'(iss_if.valid), 32'(BYP));
    chk("byp_orig0", iss_if.valid ? iss_if.instr.orig_instr : 32'h0, BYP ? 32'h13 : 32'h0);
    chk("byp_usage0", 32'(usage), 32'h0);
    @(posedge clk); #1;
    drive(0, 0, 32'h0, 0, 1);
    #1;
    chk("byp_valid1", 32'(iss_if.valid), 32'(!BYP));
    chk("byp_orig1", iss_if.valid ? iss_if.instr.orig_instr : 32'h0, BYP ? 32'h0 : 32'h13);
    chk("byp_pc1", iss_if.valid ? iss_if.instr.sbe.pc : 32'h0, BYP ? 32'h0 : 32'hD000_0000);
    chk("byp_usage1", 32'(usage), BYP ? 32'h0 : 32'h1);
    @(posedge clk); #1;
    drive(0, 0, 32'h0, 0, 0);
    #1;
    chk("byp_usage2", 32'(usage), 32'h0);
    chk("byp_valid2", 32'(iss_if.valid), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
